// File: rtl/gpio_pad_ctrl.sv
// Core-side controller for a bank of bidirectional pad cells: direction/output
// registers, input synchronisation, edge detection and a level interrupt.
module gpio_pad_ctrl #(
    parameter int NUM_PINS   = 8,
    parameter int CONF_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_i,
    input  logic                           we_i,
    input  logic [2:0]                     addr_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           rvalid_o,
    output logic [NUM_PINS*CONF_WIDTH-1:0] cell_cfg_o,
    output logic [NUM_PINS-1:0]            cell_out_o,
    input  logic [NUM_PINS-1:0]            cell_in_i,
    output logic                           irq_o
);

    localparam int PW = CONF_WIDTH - 1;

    localparam logic [2:0] A_DIR     = 3'd0;
    localparam logic [2:0] A_OUT     = 3'd1;
    localparam logic [2:0] A_IN      = 3'd2;
    localparam logic [2:0] A_RISE_EN = 3'd3;
    localparam logic [2:0] A_FALL_EN = 3'd4;
    localparam logic [2:0] A_PEND    = 3'd5;
    localparam logic [2:0] A_PADCFG  = 3'd6;

    logic [NUM_PINS-1:0]   dir_q, dir_d;
    logic [NUM_PINS-1:0]   out_q, out_d;
    logic [NUM_PINS-1:0]   rise_en_q, rise_en_d;
    logic [NUM_PINS-1:0]   fall_en_q, fall_en_d;
    logic [NUM_PINS-1:0]   pend_q, pend_d;
    logic [PW-1:0]         padcfg_q, padcfg_d;
    logic [NUM_PINS-1:0]   sync1_q, sync2_q, prev_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q;

    logic                  wr;
    logic                  rd;
    logic [NUM_PINS-1:0]   wbits;
    logic [NUM_PINS-1:0]   rise;
    logic [NUM_PINS-1:0]   fall;
    logic [NUM_PINS-1:0]   set_ev;
    logic [NUM_PINS-1:0]   clr_ev;

    // Bus bits beyond the implemented field widths are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

    always_comb begin
        wr    = req_i & we_i;
        rd    = req_i & ~we_i;
        wbits = wdata_i[NUM_PINS-1:0];

        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        padcfg_d  = padcfg_q;
        clr_ev    = '0;
        if (wr) begin
            case (addr_i)
                A_DIR:     dir_d     = wbits;
                A_OUT:     out_d     = wbits;
                A_RISE_EN: rise_en_d = wbits;
                A_FALL_EN: fall_en_d = wbits;
                A_PEND:    clr_ev    = wbits;
                A_PADCFG:  padcfg_d  = wdata_i[PW-1:0];
                default:   ;
            endcase
        end

        // Pins configured as outputs never raise events; a set beats a same-cycle clear.
        rise   = sync2_q & ~prev_q & dir_q;
        fall   = ~sync2_q & prev_q & dir_q;
        set_ev = (rise & rise_en_q) | (fall & fall_en_q);
        pend_d = (pend_q & ~clr_ev) | set_ev;

        rdata_d = '0;
        if (rd) begin
            case (addr_i)
                A_DIR:     rdata_d[NUM_PINS-1:0] = dir_q;
                A_OUT:     rdata_d[NUM_PINS-1:0] = out_q;
                A_IN:      rdata_d[NUM_PINS-1:0] = sync2_q;
                A_RISE_EN: rdata_d[NUM_PINS-1:0] = rise_en_q;
                A_FALL_EN: rdata_d[NUM_PINS-1:0] = fall_en_q;
                A_PEND:    rdata_d[NUM_PINS-1:0] = pend_q;
                A_PADCFG:  rdata_d[PW-1:0]       = padcfg_q;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q     <= '1;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            padcfg_q  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            padcfg_q  <= padcfg_d;
            sync1_q   <= cell_in_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            rdata_q   <= rdata_d;
            rvalid_q  <= req_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_cfg
            assign cell_cfg_o[gi*CONF_WIDTH +: CONF_WIDTH] = {padcfg_q, dir_q[gi]};
        end
    endgenerate

    assign cell_out_o = out_q;
    assign irq_o      = |pend_q;
    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_gpio_pad_ctrl;

    localparam int NP = 8;
    localparam int CW = 3;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_i;
    logic            we_i;
    logic [2:0]      addr_i;
    logic [DW-1:0]   wdata_i;
    logic [DW-1:0]   rdata_o;
    logic            rvalid_o;
    logic [NP*CW-1:0] cell_cfg_o;
    logic [NP-1:0]   cell_out_o;
    logic [NP-1:0]   cell_in_i;
    logic            irq_o;

    gpio_pad_ctrl #(.NUM_PINS(NP), .CONF_WIDTH(CW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .cell_cfg_o(cell_cfg_o), .cell_out_o(cell_out_o), .cell_in_i(cell_in_i),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [NP-1:0]  m_dir, m_out, m_ren, m_fen, m_pend;
    logic [CW-2:0]  m_pad;
    logic [NP-1:0]  smp [0:2];   // pad samples taken at the last three edges, [0] newest
    logic [DW-1:0]  e_rdata;
    logic           e_rvalid;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_dir = '1; m_out = '0; m_ren = '0; m_fen = '0; m_pend = '0; m_pad = '0;
        for (int i = 0; i < 3; i++) smp[i] = '0;
        e_rdata = '0; e_rvalid = 1'b0;
    endfunction

    // IN seen by the core is the pad as sampled two edges earlier
    function automatic logic [DW-1:0] reg_val(input logic [2:0] a);
        logic [DW-1:0] v;
        v = '0;
        case (a)
            3'd0: v[NP-1:0] = m_dir;
            3'd1: v[NP-1:0] = m_out;
            3'd2: v[NP-1:0] = smp[1];
            3'd3: v[NP-1:0] = m_ren;
            3'd4: v[NP-1:0] = m_fen;
            3'd5: v[NP-1:0] = m_pend;
            3'd6: v[CW-2:0] = m_pad;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic void model_edge(input logic req, input logic we, input logic [2:0] a,
                                       input logic [DW-1:0] w, input logic [NP-1:0] pins);
        logic [NP-1:0] in_now, in_old, ev, clr;
        in_now = smp[1];
        in_old = smp[2];
        ev = '0;
        for (int k = 0; k < NP; k++) begin
            if (m_dir[k] && m_ren[k] && in_now[k] && !in_old[k]) ev[k] = 1'b1;
            if (m_dir[k] && m_fen[k] && !in_now[k] && in_old[k]) ev[k] = 1'b1;
        end
        e_rvalid = req;
        e_rdata  = (req && !we) ? reg_val(a) : '0;
        clr = '0;
        if (req && we) begin
            case (a)
                3'd0: m_dir = w[NP-1:0];
                3'd1: m_out = w[NP-1:0];
                3'd3: m_ren = w[NP-1:0];
                3'd4: m_fen = w[NP-1:0];
                3'd5: clr   = w[NP-1:0];
                3'd6: m_pad = w[CW-2:0];
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | ev;
        smp[2] = smp[1];
        smp[1] = smp[0];
        smp[0] = pins;
    endfunction

    task automatic compare_all();
        logic [NP*CW-1:0] ecfg;
        for (int k = 0; k < NP; k++) ecfg[k*CW +: CW] = {m_pad, m_dir[k]};
        chk("rvalid", {31'b0, rvalid_o}, {31'b0, e_rvalid});
        chk("rdata", rdata_o, e_rdata);
        chk("cell_out", {24'b0, cell_out_o}, {24'b0, m_out});
        chk("cell_cfg", {8'b0, cell_cfg_o}, {8'b0, ecfg});
        chk("irq", {31'b0, irq_o}, {31'b0, |m_pend});
    endtask

    // One bus cycle: drive, clock, advance model, then sample 1 time unit later
    task automatic step(input logic req, input logic we, input logic [2:0] a,
                        input logic [DW-1:0] w, input logic [NP-1:0] pins);
        req_i = req; we_i = we; addr_i = a; wdata_i = w; cell_in_i = pins;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(req, we, a, w, pins);
        #1;
        compare_all();
        if (req)
            $display("t=%0t %s addr=%0d wdata=0x%0h rdata=0x%0h pins=0x%0h irq=%0b",
                     $time, we ? "WR" : "RD", a, w, rdata_o, pins, irq_o);
    endtask

    task automatic idle(input logic [NP-1:0] pins);
        step(1'b0, 1'b0, 3'd0, '0, pins);
    endtask

    task automatic mid_reset(input logic [NP-1:0] pins);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        idle(pins);
        reset = 1'b0;
    endtask

    logic [NP-1:0] pins_r;

    initial begin
        reset = 1'b1; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; cell_in_i = '0;
        model_reset();
        idle('0);
        idle('0);
        reset = 1'b0;

        // Reset state, literal expectations
        chk("rst_cfg_lit", {8'b0, cell_cfg_o}, 32'h0024_9249);
        chk("rst_irq_lit", {31'b0, irq_o}, 32'd0);
        step(1, 0, 3'd0, '0, '0);
        chk("rst_dir_lit", rdata_o, 32'h0000_00FF);
        for (int a = 1; a < 8; a++) begin
            step(1, 0, a[2:0], '0, '0);
            chk("rst_reg_lit", rdata_o, 32'd0);
        end

        // Output / config registers
        step(1, 1, 3'd0, 32'hFFFF_FFF0, '0);
        step(1, 1, 3'd1, 32'h0000_000A, '0);
        step(1, 1, 3'd6, 32'hFFFF_FFFF, '0);
        chk("out_lit", {24'b0, cell_out_o}, 32'h0A);
        chk("pin0_cfg_lit", {29'b0, cell_cfg_o[2:0]}, 32'd6);
        chk("pin7_cfg_lit", {29'b0, cell_cfg_o[23:21]}, 32'd7);
        step(1, 0, 3'd0, '0, '0);
        chk("dir_rd_lit", rdata_o, 32'hF0);
        step(1, 0, 3'd6, '0, '0);
        chk("pad_rd_lit", rdata_o, 32'h3);

        // Rising edge on pin 0
        step(1, 1, 3'd0, 32'hFF, '0);
        step(1, 1, 3'd3, 32'h01, '0);
        idle(8'h01);
        idle(8'h01);
        chk("pre_pend_irq_lit", {31'b0, irq_o}, 32'd0);
        step(1, 0, 3'd2, '0, 8'h01);
        chk("in_rd_lit", rdata_o, 32'h01);
        chk("rise_irq_lit", {31'b0, irq_o}, 32'd1);
        step(1, 1, 3'd5, 32'h01, 8'h01);
        chk("w1c_irq_lit", {31'b0, irq_o}, 32'd0);

        // Falling edge on pin 7 colliding with a clear: set wins
        step(1, 1, 3'd4, 32'h80, 8'h01);
        idle(8'h81); idle(8'h81); idle(8'h81);
        idle(8'h01);
        idle(8'h01);
        step(1, 1, 3'd5, 32'h80, 8'h01);
        chk("set_wins_irq_lit", {31'b0, irq_o}, 32'd1);
        step(1, 0, 3'd5, '0, 8'h01);
        chk("set_wins_pend_lit", rdata_o, 32'h80);
        step(1, 1, 3'd5, 32'h80, 8'h01);

        // Output-direction pin must not raise events
        step(1, 1, 3'd0, 32'hF7, 8'h01);
        step(1, 1, 3'd3, 32'h08, 8'h01);
        idle(8'h09); idle(8'h09); idle(8'h09); idle(8'h01);
        step(1, 0, 3'd5, '0, 8'h01);
        chk("outpin_pend_lit", rdata_o, 32'd0);
        step(1, 1, 3'd7, 32'hDEAD_BEEF, 8'h01);
        step(1, 0, 3'd7, '0, 8'h01);
        chk("reserved_lit", rdata_o, 32'd0);

        // Reset with PEND = 0x05 and a read in flight
        step(1, 1, 3'd0, 32'hFF, 8'h00);
        step(1, 1, 3'd3, 32'h05, 8'h00);
        step(1, 1, 3'd4, 32'h00, 8'h00);
        idle(8'h00); idle(8'h00); idle(8'h00);
        idle(8'h05); idle(8'h05); idle(8'h05);
        chk("pre_rst_irq_lit", {31'b0, irq_o}, 32'd1);
        step(1, 0, 3'd5, '0, 8'h05);
        chk("pre_rst_pend_lit", rdata_o, 32'h05);
        mid_reset(8'h05);
        chk("post_rst_rvalid_lit", {31'b0, rvalid_o}, 32'd0);
        chk("post_rst_irq_lit", {31'b0, irq_o}, 32'd0);
        step(1, 0, 3'd0, '0, 8'h05);
        chk("post_rst_dir_lit", rdata_o, 32'hFF);
        step(1, 0, 3'd5, '0, 8'h05);
        chk("post_rst_pend_lit", rdata_o, 32'd0);
        idle(8'h05); idle(8'h05); idle(8'h05);
        chk("post_rst_noirq_lit", {31'b0, irq_o}, 32'd0);

        // Randomized traffic against the model
        pins_r = 8'h05;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) pins_r = NP'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                mid_reset(pins_r);
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                     3'($urandom_range(0, 7)), $urandom, pins_r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
Core-side controller for a bank of bidirectional pad cells. It holds the direction and output registers that drive each cell's config and FROM_CORE inputs. It synchronises the cells' TO_CORE inputs into the clock domain and detects edges on them. It raises a level interrupt from per-pin rising/falling-edge pending bits and sits between the SoC register bus and the io pad ring.

Parameters:
NUM_PINS, 8, number of pad cells controlled (1..32)
CONF_WIDTH, 3, config width per cell; bit 0 is direction (1 = input, 0 = output)
DATA_WIDTH, 32, register bus data width (>= NUM_PINS)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
req_i  input  1  register access request, one-cycle strobe
we_i  input  1  1 = write, 0 = read (sampled with req_i)
addr_i  input  3  register index
wdata_i  input  DATA_WIDTH  write data
rdata_o  output  DATA_WIDTH  read data, valid when rvalid_o = 1
rvalid_o  output  1  response strobe for every request (read or write)
cell_cfg_o  output  NUM_PINS*CONF_WIDTH  per-cell config; pin k occupies [k*CONF_WIDTH +: CONF_WIDTH]
cell_out_o  output  NUM_PINS  to each cell's FROM_CORE
cell_in_i  input  NUM_PINS  from each cell's TO_CORE (asynchronous)
irq_o  output  1  level interrupt

Behaviour:
- Decided: one clock `clk`; `reset` asynchronous, active-high; all flops clear on assertion and release on the next clock edge.
- Register map (bits above NUM_PINS read 0 and ignore writes):
  - 0 DIR (RW): reset all 1s.
  - 1 OUT (RW): reset 0.
  - 2 IN (RO): synchronised pin state.
  - 3 RISE_EN (RW): reset 0.
  - 4 FALL_EN (RW): reset 0.
  - 5 PEND (W1C): reset 0.
  - 6 PADCFG (RW): CONF_WIDTH-1 bits, shared upper config for all cells, reset 0.
  - 7: reserved; reads 0, writes ignored.
- Bus timing:
  - req_i sampled on a clock edge → rvalid_o = 1 for exactly the following cycle.
  - On reads, rdata_o holds the register value as of the request edge; on writes, rdata_o = 0.
  - Back-to-back requests every cycle are supported.
  - Writes take effect at the request edge, so a read in the next cycle returns the new value.
- Outputs:
  - cell_cfg_o pin k = {PADCFG, DIR[k]}.
  - cell_out_o = OUT.
  - Both driven directly from flops; no combinational path from the bus.
- Input path:
  - 2-flop synchroniser per pin, reset 0; IN = second stage.
  - A third flop holds the previous value for edge detection.
  - rise[k] = IN[k] & ~prev[k] & DIR[k]; fall[k] = ~IN[k] & prev[k] & DIR[k]. Pins set as outputs never generate events.
  - Latency: pad change → IN after 2 edges → PEND bit set on 3rd edge → irq_o same cycle as PEND.
- Pending bits:
  - PEND[k] sets on (rise[k] & RISE_EN[k]) | (fall[k] & FALL_EN[k]).
  - Writing 1 to PEND[k] clears it; writing 0 has no effect.
  - If a set event and a W1C clear hit the same cycle, set wins and the bit stays 1.
  - Enables gate setting only; clearing an enable does not clear an already pending bit.
- irq_o = |PEND, registered-equivalent (derived only from PEND flops); reset 0.
- Reset values of all outputs:
  - rdata_o = 0, rvalid_o = 0, irq_o = 0, cell_out_o = 0.
  - cell_cfg_o = all pins with bit0 = 1 (inputs) and upper bits 0.
- Reset mid-operation:
  - A pending rvalid_o is dropped.
  - PEND clears and the synchroniser clears.
  - A pin that is high at reset release produces a rise event 3 cycles later, but RISE_EN = 0, so no PEND bit is set.

Test Plan:
- Reset then read all registers → DIR = 0xFF, OUT = 0, RISE_EN = FALL_EN = PEND = 0, PADCFG = 0; cell_cfg_o = 0x249249 (NUM_PINS=8, CONF_WIDTH=3); irq_o = 0.
- Write DIR = 0xF0, OUT = 0x0A, PADCFG = 2'b11 → next cycle cell_out_o = 0x0A; pin0 cfg = 3'b110, pin7 cfg = 3'b111; reads return the written values with rvalid one cycle after each req.
- DIR = 0xFF, RISE_EN = 0x01, drive cell_in_i[0] 0→1 → IN[0] = 1 after 2 edges; PEND = 0x01 and irq_o = 1 on the 3rd edge; write PEND = 0x01 → PEND = 0, irq_o = 0 next cycle.
- FALL_EN = 0x80 with pin7 toggling 1→0, while a PEND = 0x80 clear is issued in the same cycle as the set event → PEND[7] stays 1.
- Set DIR[3] = 0 (output) with RISE_EN[3] = 1 and toggle cell_in_i[3] → PEND stays 0; read addr 7 → rdata 0.
- Assert reset while PEND = 0x05 and a read is in flight → rvalid_o = 0, irq_o = 0, all registers at reset values on the first post-reset read.
